io_uart_xmtr: RTL

- Serial transmitter for the RISC5 system: a bus responder on the CPU I/O bus that accepts byte writes from the processor, buffers them, and shifts them out as asynchronous serial frames on txd.
- Sits beside the CPU in the risc5 top level; the counterpart of the serial receiver on the same line.
- Frame format is 8N1 by default; even parity is compile-time optional.

---
 rtl/io_uart_pkg.sv | 26 ++
 rtl/io_uart_fifo.sv | 51 +++++
 rtl/io_uart_xmtr.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/io_uart_pkg.sv
// Shared definitions for the RISC5 serial transmitter: FSM states,
// bus register map and status bit positions.
`timescale 1ns/1ps
package io_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int ST_RDY  = 0;
  localparam int ST_IDLE = 1;
  localparam int ST_PAR  = 2;

  // Bit period in clock cycles, rounded to the nearest integer.
  function automatic int uart_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/io_uart_fifo.sv
// Circular synchronous FIFO with one extra pointer bit to tell full from empty.
`timescale 1ns/1ps
module io_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/io_uart_xmtr.sv
// RISC5 serial transmitter: bus responder, transmit FIFO and frame shifter.
// Define UART_PARITY_EN to append an even parity bit to every frame.
`timescale 1ns/1ps
module io_uart_xmtr
  import io_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        txd
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          par_q, par_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rd_data;
  logic          bit_end, idle, rd_req;
  logic [31:0]   status;
  logic          unused_data_hi;

  assign unused_data_hi = ^data_in[31:8];

  // Bus decode; reset masks every access so a coincident write is dropped.
  assign rd_req    = stb & ~we & ~rst;
  assign fifo_push = stb & we & (addr == ADDR_DATA) & ~fifo_full & ~rst;
  assign ack       = stb & ~rst & (~we | (addr == ADDR_STAT) | ~fifo_full);

  io_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (data_in[7:0]),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_end = (baud_q == BAUD_LAST);
  assign idle    = fifo_empty & (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = bit_end ? '0 : baud_q + BW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          par_d    = ^fifo_rd_data;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Reload straight from the FIFO so consecutive frames have no gap.
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            par_d    = ^fifo_rd_data;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase

    status          = '0;
    status[ST_RDY]  = ~fifo_full;
    status[ST_IDLE] = idle;
`ifdef UART_PARITY_EN
    status[ST_PAR]  = 1'b1;
`else
    status[ST_PAR]  = 1'b0;
`endif

    data_out = '0;
    if (rd_req && (addr == ADDR_STAT)) data_out = status;
  end

  assign txd = txd_q;

endmodule
